instr_fetch_unit: RTL and testbench

Producer side of the `Instr` interface consumed by `control_unit`. Holds the fetch PC and issues in-order word requests to instruction memory over a valid/ready channel. Buffers returned words in a small prefetch FIFO and hands them to decode with a valid/ready handshake. Applies PC redirects (branch/JAL/JALR targets resolved downstream), flushing the FIFO and discarding stale in-flight responses.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {RUN, DRAIN} fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO of {instruction, pc} entries with synchronous flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    // Storage is left unreset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC, credit-limited memory requests, prefetch buffer and redirect drain
// Optional StallCount output is built when FETCH_STALL_CNT_EN is defined.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] IMemAddr,
    output logic        IMemReqValid,
    input  logic        IMemReqReady,
    input  logic        IMemRspValid,
    input  logic [31:0] IMemRspData,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0] StallCount
`endif
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] outstanding_next;
    logic [CW:0]   credit_used;
    logic [31:0]   redirect_pc_al;
    logic          req_fire;
    logic          rsp_fire;
    logic          rsp_keep;
    logic          pop;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;

    assign redirect_pc_al = RedirectPC & 32'hFFFF_FFFC;
    assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding};

    // Gated by rst_n so nothing is offered while reset is held.
    assign IMemReqValid = rst_n && (state == RUN) && !Redirect && !fifo_full
                        && (credit_used < (CW + 1)'(DEPTH));
    assign IMemAddr     = fetch_pc;
    assign req_fire     = IMemReqValid && IMemReqReady;

    // Responses with nothing outstanding are protocol errors and are ignored.
    assign rsp_fire   = IMemRspValid && (outstanding != '0);
    assign rsp_keep   = rsp_fire && (state == RUN) && !Redirect;
    assign push_entry = '{instr: IMemRspData, pc: rsp_pc};

    assign InstrValid = rst_n && !fifo_empty && !Redirect;
    assign pop        = InstrValid && InstrReady;
    assign Instr      = InstrValid ? fifo_head.instr : NOP_INSTR;
    assign InstrPC    = InstrValid ? fifo_head.pc : 32'h0;

    // Outstanding counts every in-flight request, stale or not; on a redirect
    // all of them become stale, so its next value is also the new drop count.
    assign outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_fire);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (Redirect),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (Redirect) begin
                fetch_pc <= redirect_pc_al;
                rsp_pc   <= redirect_pc_al;
                drop_cnt <= outstanding_next;
                state    <= ((state == DRAIN) || (outstanding_next != '0)) ? DRAIN : RUN;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_keep) begin
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (state == DRAIN) begin
                    if (rsp_fire && (drop_cnt != '0)) begin
                        drop_cnt <= drop_cnt - CW'(1);
                    end
                    if ((drop_cnt == '0) || (rsp_fire && (drop_cnt == CW'(1)))) begin
                        state <= RUN;
                    end
                end
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= 32'h0;
        end else if (InstrReady && !InstrValid) begin
            StallCount <= StallCount + 32'd1;
        end
    end
`endif

    rsp_needs_request: assert property (@(posedge clk) disable iff (!rst_n)
        IMemRspValid |-> (outstanding != '0));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector bench for instr_fetch_unit with an in-order memory model
module tb_instr_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] IMemAddr;
    logic        IMemReqValid;
    logic        IMemReqReady = 1'b1;
    logic        IMemRspValid = 1'b0;
    logic [31:0] IMemRspData = 32'h0;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrValid;
    logic        InstrReady = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = 32'h0;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] StallCount;
`endif

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IMemAddr     (IMemAddr),
        .IMemReqValid (IMemReqValid),
        .IMemReqReady (IMemReqReady),
        .IMemRspValid (IMemRspValid),
        .IMemRspData  (IMemRspData),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady),
        .Redirect     (Redirect),
        .RedirectPC   (RedirectPC)
`ifdef FETCH_STALL_CNT_EN
        ,
        .StallCount   (StallCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          redir;
        logic [31:0] rpc;
        bit          exp_rv;
        logic [31:0] exp_addr;
        bit          exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    pend_t       pend[$];
    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    bit          hs_pending = 1'b0;
    logic [31:0] hs_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'h0013} ^ 32'h5A00_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic v(input bit rst, input bit rdy, input bit redir, input logic [31:0] rpc,
                     input bit exp_rv, input logic [31:0] exp_addr,
                     input bit exp_iv, input logic [31:0] exp_pc);
        vecs.push_back('{rst, rdy, redir, rpc, exp_rv, exp_addr, exp_iv, exp_pc});
    endtask

    // Called after outputs settle; records the request handshake of this cycle.
    task automatic sample();
        hs_pending = IMemReqValid && IMemReqReady;
        hs_addr    = IMemAddr;
    endtask

    // Memory returns one word per cycle, in order, mem_lat cycles after acceptance.
    task automatic advance();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (hs_pending) pend.push_back('{hs_addr, cyc - 1 + mem_lat});
        hs_pending = 1'b0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            IMemRspValid = 1'b1;
            IMemRspData  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            IMemRspValid = 1'b0;
            IMemRspData  = 32'h0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        pend.delete();
        hs_pending   = 1'b0;
        IMemRspValid = 1'b0;
        IMemRspData  = 32'h0;
        Redirect     = 1'b0;
        InstrReady   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(IMemReqValid), 32'h0);
        check("rst_instr_valid", 32'(InstrValid), 32'h0);
        check("rst_instr", Instr, NOP);
        check("rst_instr_pc", InstrPC, 32'h0);
`ifdef FETCH_STALL_CNT_EN
        check("rst_stall_count", StallCount, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Streaming with 1-cycle memory, then a redirect coinciding with a
        // response and a would-be decode handshake.
        v(1, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0);
        v(0, 1, 0, 32'h0,   1, 32'h4,   0, 32'h0);
        v(0, 1, 0, 32'h0,   1, 32'h8,   1, 32'h0);
        v(0, 1, 0, 32'h0,   1, 32'hC,   1, 32'h4);
        v(0, 1, 1, 32'h203, 0, 32'h0,   0, 32'h0);
        v(0, 1, 0, 32'h0,   1, 32'h200, 0, 32'h0);
        v(0, 1, 0, 32'h0,   1, 32'h204, 0, 32'h0);
        v(0, 1, 0, 32'h0,   1, 32'h208, 1, 32'h200);
        v(0, 1, 0, 32'h0,   1, 32'h20C, 1, 32'h204);
        // Backpressure: four requests fill the credit, then decode drains in order.
        v(1, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0);
        v(0, 0, 0, 32'h0,   1, 32'h4,   0, 32'h0);
        v(0, 0, 0, 32'h0,   1, 32'h8,   1, 32'h0);
        v(0, 0, 0, 32'h0,   1, 32'hC,   1, 32'h0);
        v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0);
        v(0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h0);
        v(0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h0);
        v(0, 1, 0, 32'h0,   1, 32'h10,  1, 32'h4);
        v(0, 1, 0, 32'h0,   1, 32'h14,  1, 32'h8);
        v(0, 1, 0, 32'h0,   1, 32'h18,  1, 32'hC);
        v(0, 1, 0, 32'h0,   1, 32'h1C,  1, 32'h10);
        v(0, 1, 0, 32'h0,   1, 32'h20,  1, 32'h14);

        mem_lat = 1;
        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            InstrReady = vecs[i].rdy;
            Redirect   = vecs[i].redir;
            RedirectPC = vecs[i].rpc;
            #1;
            check($sformatf("v%0d_req_valid", i), 32'(IMemReqValid), 32'(vecs[i].exp_rv));
            if (vecs[i].exp_rv) check($sformatf("v%0d_addr", i), IMemAddr, vecs[i].exp_addr);
            check($sformatf("v%0d_instr_valid", i), 32'(InstrValid), 32'(vecs[i].exp_iv));
            if (vecs[i].exp_iv) begin
                check($sformatf("v%0d_instr_pc", i), InstrPC, vecs[i].exp_pc);
                check($sformatf("v%0d_instr", i), Instr, mem_word(vecs[i].exp_pc));
            end else begin
                check($sformatf("v%0d_instr_nop", i), Instr, NOP);
            end
            sample();
            advance();
        end
        Redirect = 1'b0;

        // Redirect with two stale requests in flight on a 3-cycle memory.
        mem_lat = 3;
        do_reset();
        InstrReady = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check($sformatf("drain_pre_addr%0d", k), IMemAddr, 32'(4 * k));
            sample();
            advance();
        end
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_0103;
        #1;
        check("drain_redirect_req_valid", 32'(IMemReqValid), 32'h0);
        check("drain_redirect_instr_valid", 32'(InstrValid), 32'h0);
        sample();
        advance();
        Redirect = 1'b0;
        begin
            bit          seen_req = 1'b0;
            bit          seen_iv = 1'b0;
            int          req_cyc = -1;
            int          iv_cyc = -1;
            logic [31:0] req_addr = 32'h0;
            logic [31:0] iv_pc = 32'h0;
            logic [31:0] iv_instr = 32'h0;
            for (int k = 0; k < 30 && !seen_iv; k++) begin
                #1;
                if (IMemReqValid && !seen_req) begin
                    seen_req = 1'b1;
                    req_cyc  = cyc;
                    req_addr = IMemAddr;
                end
                if (InstrValid) begin
                    seen_iv  = 1'b1;
                    iv_cyc   = cyc;
                    iv_pc    = InstrPC;
                    iv_instr = Instr;
                end else begin
                    sample();
                    advance();
                end
            end
            check("drain_instr_seen", 32'(seen_iv), 32'h1);
            check("drain_first_req_addr", req_addr, 32'h100);
            check("drain_first_req_cycle", 32'(req_cyc), 32'd5);
            check("drain_first_pc", iv_pc, 32'h100);
            check("drain_first_instr", iv_instr, mem_word(32'h100));
            check("drain_first_valid_cycle", 32'(iv_cyc), 32'd9);
        end

        // Reset asserted between clock edges in the middle of a stream.
        mem_lat = 1;
        do_reset();
        InstrReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            sample();
            advance();
        end
        #1;
        check("burst_instr_valid", 32'(InstrValid), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_req_valid", 32'(IMemReqValid), 32'h0);
        check("async_rst_instr_valid", 32'(InstrValid), 32'h0);
        check("async_rst_instr", Instr, NOP);
        check("async_rst_instr_pc", InstrPC, 32'h0);
        pend.delete();
        hs_pending   = 1'b0;
        IMemRspValid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_req_valid", 32'(IMemReqValid), 32'h1);
        check("post_rst_addr", IMemAddr, 32'h0);

`ifdef FETCH_STALL_CNT_EN
        do_reset();
        IMemReqReady = 1'b0;
        InstrReady   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            sample();
            advance();
        end
        #1;
        check("stall_count", StallCount, 32'd5);
        IMemReqReady = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
